// File: rtl/router_sync_ctrl_if.sv
// Interface bundling the router_sync_ctrl handshake and status signals.
// master: the FSM/FIFO/client side that drives the controller inputs.
// slave : the router_sync_ctrl block itself.
// Optional build macro ROUTER_SYNC_STICKY_EN adds the timeout_sticky status bits.
interface router_sync_ctrl_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
);
  logic                 detect_add;
  logic [ADDR_W-1:0]    data_in;
  logic                 write_enb_reg;
  logic [NUM_PORTS-1:0] read_enb;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] valid_out;
  logic [NUM_PORTS-1:0] write_enb;
  logic [NUM_PORTS-1:0] soft_reset;
`ifdef ROUTER_SYNC_STICKY_EN
  logic [NUM_PORTS-1:0] timeout_sticky;

  modport master (
    output detect_add, data_in, write_enb_reg, read_enb, empty, full,
    input  fifo_full, valid_out, write_enb, soft_reset, timeout_sticky
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg, read_enb, empty, full,
    output fifo_full, valid_out, write_enb, soft_reset, timeout_sticky
  );
`else
  modport master (
    output detect_add, data_in, write_enb_reg, read_enb, empty, full,
    input  fifo_full, valid_out, write_enb, soft_reset
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg, read_enb, empty, full,
    output fifo_full, valid_out, write_enb, soft_reset
  );
`endif
endinterface

// File: rtl/router_sync_ctrl.sv
// router_sync_ctrl: sits in front of the per-destination output FIFOs of the
// 1x3 router. Latches the packet destination, steers the FSM write strobe to
// the addressed FIFO, returns that FIFO's full flag, presents valid_out and
// flushes a FIFO (soft_reset) when its client stalls for TIMEOUT cycles.
// Optional build macro ROUTER_SYNC_STICKY_EN adds per-port timeout_sticky flags
// that record a timeout until the port is addressed again.
module router_sync_ctrl #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = 30
) (
  input  logic                clock,
  input  logic                reset,
  router_sync_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    addr_d;
  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] soft_reset_q;
  logic [NUM_PORTS-1:0] soft_reset_d;
  logic [NUM_PORTS-1:0] write_enb_s;
  logic                 fifo_full_s;
  logic [NUM_PORTS-1:0] valid_out_s;

  // Destination address next-state: capture on detect_add, otherwise hold.
  always_comb begin
    addr_d = addr_q;
    if (bus.detect_add) begin
      addr_d = bus.data_in;
    end else begin
      addr_d = addr_q;
    end
  end

  // Decode the latched address; an out-of-range address matches no port so
  // the packet is dropped and fifo_full reads 0.
  always_comb begin
    write_enb_s = {NUM_PORTS{1'b0}};
    fifo_full_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        write_enb_s[i] = bus.write_enb_reg;
        fifo_full_s    = bus.full[i];
      end else begin
        write_enb_s[i] = 1'b0;
      end
    end
  end

  assign valid_out_s = ~bus.empty;

  // Per-port stall counters: count stalled cycles, pulse soft_reset on the
  // TIMEOUT-th and restart from 0 so two pulses can never be adjacent.
  always_comb begin
    soft_reset_d = {NUM_PORTS{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = {CNT_W{1'b0}};
      if (valid_out_s[i] && !bus.read_enb[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]        = {CNT_W{1'b0}};
          soft_reset_d[i] = 1'b1;
        end else begin
          cnt_d[i]        = cnt_q[i] + CNT_W'(1);
          soft_reset_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i]        = {CNT_W{1'b0}};
        soft_reset_d[i] = 1'b0;
      end
    end
  end

  // State registers; reset parks the address on an invalid port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q       <= {ADDR_W{1'b1}};
      soft_reset_q <= {NUM_PORTS{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      addr_q       <= addr_d;
      soft_reset_q <= soft_reset_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.write_enb  = write_enb_s;
  assign bus.fifo_full  = fifo_full_s;
  assign bus.valid_out  = valid_out_s;
  assign bus.soft_reset = soft_reset_q;

`ifdef ROUTER_SYNC_STICKY_EN
  logic [NUM_PORTS-1:0] sticky_q;
  logic [NUM_PORTS-1:0] sticky_d;

  // Sticky timeout flags: set by a timeout, cleared when the port is
  // addressed again; a timeout in the same cycle wins.
  always_comb begin
    sticky_d = sticky_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (soft_reset_d[i]) begin
        sticky_d[i] = 1'b1;
      end else if (bus.detect_add && (bus.data_in == ADDR_W'(i))) begin
        sticky_d[i] = 1'b0;
      end else begin
        sticky_d[i] = sticky_q[i];
      end
    end
  end

  // Sticky flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sticky_q <= {NUM_PORTS{1'b0}};
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.timeout_sticky = sticky_q;
`endif

endmodule
